// File: rtl/time_mux_scan_if.sv
`default_nettype none
// ============================================================================
//  Module      : time_mux_scan_if
//  Description : Bundle of scan-control inputs and scan outputs shared by the
//                time-multiplexing scanner and whatever drives it.
//                master : source side; drives en/dwell/blank/mask/d and
//                         observes y/b/idx/slot_start.
//                slave  : scanner side; the opposite directions.
//  Signals     : en         - scan tick
//                dwell      - slot length minus 1, in ticks
//                blank      - blanking ticks between slots (0 = no gap)
//                mask       - per-channel enables
//                d          - packed channel data, channel i at d[i*N +: N]
//                y          - selected channel data
//                b          - one-hot select of the shown channel
//                idx        - index of the current or last shown channel
//                slot_start - pulse on the first cycle of each slot
//  Revision    : 1.0 - initial release
// ============================================================================
interface time_mux_scan_if #(
    parameter int N  = 1,
    parameter int M  = 2,
    parameter int DW = 8,
    parameter int BW = 4
);
    localparam int CW = (M > 1) ? $clog2(M) : 1;

    logic            en;
    logic [DW-1:0]   dwell;
    logic [BW-1:0]   blank;
    logic [M-1:0]    mask;
    logic [M*N-1:0]  d;
    logic [N-1:0]    y;
    logic [M-1:0]    b;
    logic [CW-1:0]   idx;
    logic            slot_start;

    modport master (
        output en, dwell, blank, mask, d,
        input  y, b, idx, slot_start
    );

    modport slave (
        input  en, dwell, blank, mask, d,
        output y, b, idx, slot_start
    );
endinterface
`default_nettype wire

// File: rtl/time_mux_scan.sv
`default_nettype none
// ============================================================================
//  Module      : time_mux_scan
//  Description : M-channel, N-bit time-multiplexing scanner. Visits enabled
//                channels in round-robin order, holding each for a
//                programmable dwell and optionally inserting a blanking gap
//                between slots. Counting advances only on en ticks; mask
//                drops act immediately.
//  Ports       : clk   - clock
//                reset - synchronous active-high reset
//                bus   - time_mux_scan_if.slave (en, dwell, blank, mask, d in;
//                        y, b, idx, slot_start out, all registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module time_mux_scan #(
    parameter int N  = 1,
    parameter int M  = 2,
    parameter int DW = 8,
    parameter int BW = 4
) (
    input wire             clk,
    input wire             reset,
    time_mux_scan_if.slave bus
);

    localparam int CW   = (M > 1) ? $clog2(M) : 1;
    localparam int CNTW = (DW > BW) ? DW : BW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   idx_q, idx_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [N-1:0]    y_q, y_d;
    logic [M-1:0]    b_q, b_d;
    logic            slot_start_q, slot_start_d;

    logic [CW-1:0]   next_incl;
    logic [CW-1:0]   next_excl;
    logic            cur_enabled;
    logic [N-1:0]    cur_data;
    logic            go_show;
    logic [CW-1:0]   go_sel;

    // Round-robin search from 'start'. Candidates are visited by descending
    // distance so the last hit (nearest in scan order) wins. The inclusive
    // form considers distances 0..M-1, the exclusive form 1..M (start last).
    function automatic logic [CW-1:0] search(
        input logic [CW-1:0] start,
        input logic [M-1:0]  m,
        input logic          inclusive
    );
        logic [CW-1:0] sel;
        logic [CW:0]   pos;
        logic [M-1:0]  shifted;
        sel = start;
        for (int k = M; k >= 0; k--) begin
            if ((inclusive && (k < M)) || (!inclusive && (k > 0))) begin
                pos = {1'b0, start} + (CW+1)'(k);
                if (pos >= (CW+1)'(M)) begin
                    pos = pos - (CW+1)'(M);
                end
                shifted = m >> pos;
                if (shifted[0]) begin
                    sel = pos[CW-1:0];
                end
            end
        end
        return sel;
    endfunction

    assign next_incl = search(idx_q, bus.mask, 1'b1);
    assign next_excl = search(idx_q, bus.mask, 1'b0);

    // Mask bit and data of the channel currently addressed by idx.
    always_comb begin
        cur_enabled = 1'b0;
        cur_data    = '0;
        for (int i = 0; i < M; i++) begin
            if (idx_q == CW'(i)) begin
                cur_enabled = bus.mask[i];
                cur_data    = bus.d[i*N +: N];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        slot_start_d = 1'b0;
        go_show      = 1'b0;
        go_sel       = idx_q;

        if (bus.mask == '0) begin
            // Nothing left to scan: park in IDLE, idx keeps the last channel.
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.en) begin
                        go_show = 1'b1;
                        go_sel  = next_incl;
                    end
                end
                ST_SHOW: begin
                    // A channel losing its enable ends the slot at once,
                    // independent of en and of the remaining dwell.
                    if (!cur_enabled || (bus.en && (cnt_q == '0))) begin
                        if (bus.blank != '0) begin
                            state_d = ST_BLANK;
                            cnt_d   = CNTW'(bus.blank - BW'(1));
                        end else begin
                            go_show = 1'b1;
                            go_sel  = next_excl;
                        end
                    end else if (bus.en) begin
                        cnt_d = cnt_q - CNTW'(1);
                    end
                end
                ST_BLANK: begin
                    if (bus.en) begin
                        if (cnt_q == '0) begin
                            go_show = 1'b1;
                            go_sel  = next_excl;
                        end else begin
                            cnt_d = cnt_q - CNTW'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (go_show) begin
            state_d      = ST_SHOW;
            idx_d        = go_sel;
            cnt_d        = CNTW'(bus.dwell);
            slot_start_d = 1'b1;
        end

        b_d = '0;
        if (state_d == ST_SHOW) begin
            for (int i = 0; i < M; i++) begin
                b_d[i] = (idx_d == CW'(i));
            end
        end

        // y follows the channel shown during the cycle just ending, so it
        // trails b by one clock and is zero on the first cycle of a new run.
        y_d = ((state_q == ST_SHOW) && (state_d == ST_SHOW)) ? cur_data : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            y_q          <= '0;
            b_q          <= '0;
            slot_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            y_q          <= y_d;
            b_q          <= b_d;
            slot_start_q <= slot_start_d;
        end
    end

    assign bus.y          = y_q;
    assign bus.b          = b_q;
    assign bus.idx        = idx_q;
    assign bus.slot_start = slot_start_q;

endmodule
`default_nettype wire
